// File: rtl/rnd_hex_pkg.sv
// Shared types and segment encoding for the random hex display.
// Leading-zero blanking is selected with RND_HEX_LZB_EN in rnd_hex_disp.
package rnd_hex_pkg;

  typedef enum logic [1:0] {IDLE, ROLL, SHOW} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} glyphs
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter; o_level follows the
// synchronized button only after DB_CYCLES consecutive mismatching cycles.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      o_level <= 1'b0;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
      if (sync2 == o_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt     <= '0;
        o_level <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rnd_hex_disp.sv
// Button-driven roll/capture of an LFSR word, shown as multiplexed hex.
// Define RND_HEX_LZB_EN to blank leading zero digits (digit 0 never blanks).
module rnd_hex_disp
  import rnd_hex_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SCAN_DIV  = 50000,
  parameter int DB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_btn,
  input  logic [WIDTH-1:0]  i_rnd,
  output logic              o_lfsr_en,
  output logic [6:0]        o_seg,
  output logic [WIDTH/4-1:0] o_an,
  output logic              o_rolling
);
  localparam int NDIG = WIDTH / 4;
  localparam int CW   = $clog2(SCAN_DIV);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic btn_db, btn_q, press, rel;
  state_t state, state_nx;
  logic [WIDTH-1:0] value;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (i_btn),
    .o_level(btn_db)
  );

  assign press = btn_db & ~btn_q;
  assign rel   = ~btn_db & btn_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (press) state_nx = ROLL;
      ROLL:    if (rel)   state_nx = SHOW;
      SHOW:    if (press) state_nx = ROLL;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= 1'b0;
      state     <= IDLE;
      value     <= '0;
      o_lfsr_en <= 1'b0;
      o_rolling <= 1'b0;
    end else begin
      btn_q     <= btn_db;
      state     <= state_nx;
      o_lfsr_en <= (state_nx == ROLL);
      o_rolling <= (state_nx == ROLL);
      if (state == ROLL && rel) value <= i_rnd;
    end
  end

  // Scan: free-running digit timer, independent of the FSM
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  logic [NDIG-1:0][3:0] nibs;
  logic [NDIG-1:0]      hi_zero;
  logic [6:0]           seg_nx;

  assign nibs = (state == ROLL) ? i_rnd : value;

  // hi_zero[d]: nibble d and everything above it are zero
  assign hi_zero[NDIG-1] = (nibs[NDIG-1] == 4'h0);
  for (genvar d = NDIG - 2; d >= 0; d--) begin : g_hz
    assign hi_zero[d] = hi_zero[d+1] & (nibs[d] == 4'h0);
  end

  always_comb begin
    seg_nx = hex2seg(nibs[idx]);
`ifdef RND_HEX_LZB_EN
    if (idx != '0 && hi_zero[idx]) seg_nx = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_an  <= ~NDIG'(1);
      o_seg <= 7'b1000000;
    end else begin
      o_an  <= ~(NDIG'(1) << idx);
      o_seg <= seg_nx;
    end
  end

`ifndef RND_HEX_LZB_EN
  logic unused_hz;
  assign unused_hz = ^hi_zero;
`endif

endmodule

// File: tb/tb_rnd_hex_disp.sv
// Directed bench for rnd_hex_disp (WIDTH=16, SCAN_DIV=4, DB_CYCLES=3).
module tb_rnd_hex_disp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_btn;
  logic [15:0] i_rnd;
  logic        o_lfsr_en, o_rolling;
  logic [6:0]  o_seg;
  logic [3:0]  o_an;

  int n_chk = 0;
  int n_err = 0;

  rnd_hex_disp #(.WIDTH(16), .SCAN_DIV(4), .DB_CYCLES(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_btn    (i_btn),
    .i_rnd    (i_rnd),
    .o_lfsr_en(o_lfsr_en),
    .o_seg    (o_seg),
    .o_an     (o_an),
    .o_rolling(o_rolling)
  );

  always #5 clk = ~clk;

`ifdef RND_HEX_LZB_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  typedef struct {
    logic [15:0]     rnd;
    logic [3:0][6:0] seg;  // [digit]
  } vec_t;

  vec_t vecs [7];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Watch one full scan and compare each lit digit's glyph
  task automatic check_digits(input string nm, input logic [3:0][6:0] exp);
    int d;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk({nm, "_an_onehot"}, 32'($countones(~o_an)), 32'd1);
      d = 0;
      for (int b = 0; b < 4; b++) if (!o_an[b]) d = b;
      chk($sformatf("%s_dig%0d", nm, d), 32'(o_seg), 32'(exp[d]));
    end
  endtask

  initial begin
    vecs[0] = '{16'h1A2F, '{7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110}};
    vecs[1] = '{16'h00A3, '{LZ, LZ, 7'b0001000, 7'b0110000}};
    vecs[2] = '{16'h0000, '{LZ, LZ, LZ, 7'b1000000}};
    vecs[3] = '{16'h8C5E, '{7'b0000000, 7'b1000110, 7'b0010010, 7'b0000110}};
    vecs[4] = '{16'hF0B6, '{7'b0001110, 7'b1000000, 7'b0000011, 7'b0000010}};
    vecs[5] = '{16'h0907, '{LZ, 7'b0010000, 7'b1000000, 7'b1111000}};
    vecs[6] = '{16'h4D00, '{7'b0011001, 7'b0100001, 7'b1000000, 7'b1000000}};

    rst_n = 1'b1;
    i_btn = 1'b0;
    i_rnd = 16'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(o_an), 32'h_e);
    chk("rst_seg", 32'(o_seg), 32'(7'b1000000));
    chk("rst_en", 32'(o_lfsr_en), 32'd0);
    chk("rst_rolling", 32'(o_rolling), 32'd0);
    tick(2);
    @(negedge clk) rst_n = 1'b1;

    // Scan after reset: each anode held 4 cycles, all zeros
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("scan_an_k%0d", k), 32'(o_an), 32'(~(4'b0001 << (((k - 1) / 4) % 4))) & 32'hF);
      chk($sformatf("scan_seg_k%0d", k), 32'(o_seg), 32'(7'b1000000));
    end

    // Bounce rejection: 2-cycle pulses never reach 3 stable cycles
    for (int r = 0; r < 3; r++) begin
      i_btn = 1'b1;
      tick(); chk("bounce_en", 32'(o_lfsr_en), 32'd0);
      tick(); chk("bounce_en", 32'(o_lfsr_en), 32'd0);
      i_btn = 1'b0;
      tick(); chk("bounce_en", 32'(o_lfsr_en), 32'd0);
      tick(); chk("bounce_en", 32'(o_lfsr_en), 32'd0);
    end
    tick(6);
    chk("bounce_en_end", 32'(o_lfsr_en), 32'd0);
    chk("bounce_rolling_end", 32'(o_rolling), 32'd0);

    // Roll: enable appears on the 6th edge after the press
    i_rnd = 16'h1A2F;
    i_btn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("roll_en_c5", 32'(o_lfsr_en), 32'd0);
      if (e == 6) begin
        chk("roll_en_c6", 32'(o_lfsr_en), 32'd1);
        chk("roll_rolling_c6", 32'(o_rolling), 32'd1);
      end
    end
    tick(4);
    i_rnd = 16'h0000;
    tick();
    i_rnd = 16'hFFFF;
    tick();
    chk("live_seg", 32'(o_seg), 32'(7'b0001110));
    i_rnd = 16'h1A2F;
    tick(8);
    i_btn = 1'b0;
    tick(5);
    chk("rel_en_c5", 32'(o_lfsr_en), 32'd1);
    tick();
    chk("rel_en_c6", 32'(o_lfsr_en), 32'd0);
    chk("rel_rolling_c6", 32'(o_rolling), 32'd0);
    i_rnd = 16'h7777;
    check_digits("hold_1a2f", vecs[0].seg);

    // Table: capture each word, scramble i_rnd, check held glyphs
    for (int v = 0; v < 7; v++) begin
      i_btn = 1'b1;
      tick(8);
      i_rnd = vecs[v].rnd;
      tick(2);
      i_btn = 1'b0;
      tick(8);
      chk($sformatf("vec%0d_en", v), 32'(o_lfsr_en), 32'd0);
      i_rnd = ~vecs[v].rnd;
      check_digits($sformatf("vec%0d", v), vecs[v].seg);
    end

    // Reset in the middle of a roll clears enable asynchronously
    i_rnd = 16'h1234;
    i_btn = 1'b1;
    tick(8);
    chk("midroll_rolling", 32'(o_rolling), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midroll_rst_en", 32'(o_lfsr_en), 32'd0);
    chk("midroll_rst_rolling", 32'(o_rolling), 32'd0);
    i_btn = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check_digits("midroll_zero", vecs[2].seg);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
